keyboard_event_decoder: RTL and testbench
=========================================

// Module: keyboard_event_decoder
// PURPOSE
//  Consumes the 16-bit debounced key-state bitmap from the 4x4 matrix scanner and turns it into
//  discrete key events (4-bit key code plus repeat flag) with typematic auto-repeat.
//  Events are queued in a small FIFO and handed to the calculator core over a valid/ready handshake.
//  Sits between the keyboard scanner and the command decoder; same Clock domain as the scanner.
// PARAMETERS
//  RPT_DELAY   50_000_000  cycles from a press event to the first repeat event (>=2)
//  RPT_PERIOD  10_000_000  cycles between consecutive repeat events (>=2)
//  DEPTH       4           event FIFO entries; power of two, >=2
// PORTS
//  Clock      in   1   system clock
//  Reset      in   1   asynchronous, active-low reset
//  keys       in   16  key-state bitmap, bit 4*row+col = 1 while held; synchronous to Clock
//  ev_valid   out  1   FIFO head holds an event
//  ev_code    out  4   key code of head event (bit index in keys)
//  ev_repeat  out  1   head event is an auto-repeat (0 = fresh press)
//  ev_ready   in   1   consumer accepts head this cycle
//  overflow   out  1   1-cycle pulse: a repeat event was dropped because the FIFO was full
//  multi      out  1   registered; 1 while more than one bit of keys_q is set
// BEHAVIOUR
//  Reset (async, Reset=0): keys_q=0, pend=0, FIFO empty, timer FSM IDLE, counter 0, active=0;
//   ev_valid=0, ev_code=0, ev_repeat=0, overflow=0, multi=0. Reset mid-operation discards all events.
//  Press detect: press = keys & ~keys_q; each edge keys_q<=keys,
//   pend <= (pend | press) & keys & ~sel_mask. Released-before-emitted keys are silently dropped.
//  Press push: if pend!=0 and FIFO not full, lowest set bit of pend is pushed {repeat=0, code}
//   and its bit is cleared (sel_mask). One push per cycle max; higher codes wait in pend (no loss).
//  FIFO full: press stays pending until space. Full test uses the pre-pop count
//   (push blocked when full even if popping the same cycle).
//  Latency: bit rises on keys before edge k -> pend set at k -> pushed at k+1 -> ev_valid=1 after k+1
//   (FIFO empty, nothing pending).
//  Handshake: show-ahead FIFO; pop on ev_valid&&ev_ready; ev_code/ev_repeat stable while
//   ev_valid=1 && ev_ready=0. ev_ready while empty is ignored.
//  Auto-repeat FSM, timer cnt:
//   IDLE   - on press push: active<=code, cnt<=0 -> DELAY
//   DELAY  - cnt++; at cnt==RPT_DELAY-1: cnt<=0, push {1,active} -> REPEAT
//   REPEAT - cnt++; at cnt==RPT_PERIOD-1: cnt<=0, push {1,active}
//   any state: keys_q[active]==0 -> IDLE (release beats expiry in the same cycle)
//   press push in DELAY/REPEAT restarts: active<=new code, cnt<=0, DELAY; coincident repeat is dropped
//   (no overflow pulse). Press push has priority over repeat push.
//   Repeat push with FIFO full: event dropped, overflow=1 for one cycle, timer reloads normally.
//  cnt width = clog2(max(RPT_DELAY,RPT_PERIOD)); no wrap beyond terminal value.
//  FIFO pointers are clog2(DEPTH) bits, wrap naturally; count is clog2(DEPTH)+1 bits.
// STRUCTURE
//  Shared package kbd_pkg: KEY_W=16, CODE_W=4, event type {repeat, code[3:0]} (5 bits),
//   key code constants for the calculator key map (shared with the command decoder).
//  Sub-module kbd_event_fifo: sync show-ahead FIFO, params WIDTH=5/DEPTH, ports push/din/full,
//   pop/dout/empty; same Clock/Reset.
//  Top holds edge detect, pend/priority encoder, repeat FSM, multi register.
// TESTING (sim params RPT_DELAY=8, RPT_PERIOD=4, DEPTH=4)
//  1. keys 0->0x0020 held 3 cycles, ev_ready=1 -> one event code=5 repeat=0 valid 2 edges after change;
//     no repeat.
//  2. keys=0x0003 in one cycle, ev_ready=0 -> FIFO holds code 0 then code 1 (both repeat=0); multi=1.
//  3. Hold 0x8000, ev_ready=1 -> code 15 r=0, then r=1 at +8 cycles, then every 4; release -> no more.
//  4. Hold 0x0001 with ev_ready=0 until FIFO full -> next repeat dropped with 1-cycle overflow pulse;
//     then ev_ready=1 drains 4 entries in order.
//  5. Press 0x0004, then add 0x0100 during DELAY -> code 8 r=0 emitted, repeats switch to code 8,
//     timer restarted.
//  6. Reset=0 while FIFO has 3 events and FSM in REPEAT -> ev_valid=0 immediately; no events until a new press.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: widths, the queued event record, repeat-timer states
// and the calculator key map used by both this decoder and the command decoder.
package kbd_pkg;
    localparam int KEY_W  = 16;
    localparam int CODE_W = 4;

    typedef struct packed {
        logic              rpt;
        logic [CODE_W-1:0] code;
    } kbd_event_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Calculator key map: code = 4*row + col.
    localparam logic [CODE_W-1:0] KEY_7   = 4'd0,  KEY_8   = 4'd1,  KEY_9  = 4'd2,  KEY_DIV = 4'd3;
    localparam logic [CODE_W-1:0] KEY_4   = 4'd4,  KEY_5   = 4'd5,  KEY_6  = 4'd6,  KEY_MUL = 4'd7;
    localparam logic [CODE_W-1:0] KEY_1   = 4'd8,  KEY_2   = 4'd9,  KEY_3  = 4'd10, KEY_SUB = 4'd11;
    localparam logic [CODE_W-1:0] KEY_CLR = 4'd12, KEY_0   = 4'd13, KEY_EQ = 4'd14, KEY_ADD = 4'd15;

    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
        lowest_set = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CODE_W'(i);
        end
    endfunction
endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous show-ahead FIFO for key events; the head entry is visible on dout
// whenever empty is low. Full uses the pre-pop count.
module kbd_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/keyboard_event_decoder.sv
// Turns the debounced key bitmap into press / typematic-repeat events queued for the
// calculator core. Fresh presses always win over repeats for the single push slot.
module keyboard_event_decoder
    import kbd_pkg::*;
#(
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000,
    parameter int DEPTH      = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [KEY_W-1:0]  keys,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_repeat,
    input  logic              ev_ready,
    output logic              overflow,
    output logic              multi
);
    localparam int CNT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

    logic [KEY_W-1:0]  keys_q, pend_q, pend_d, press, sel_mask;
    logic [CODE_W-1:0] sel_code, active_q, active_d;
    logic              press_push, rpt_fire;
    logic              multi_q, overflow_q, overflow_d;
    rpt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fifo_full, fifo_empty, fifo_push;
    kbd_event_t        fifo_din, fifo_dout;

    // Keys released before their press could be queued fall out of pend via the & keys term.
    always_comb begin
        press      = keys & ~keys_q;
        press_push = (pend_q != '0) && !fifo_full;
        sel_code   = lowest_set(pend_q);
        sel_mask   = press_push ? (KEY_W'(1) << sel_code) : '0;
        pend_d     = (pend_q | press) & keys & ~sel_mask;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            keys_q     <= '0;
            pend_q     <= '0;
            multi_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            keys_q     <= keys;
            pend_q     <= pend_d;
            multi_q    <= (keys & (keys - KEY_W'(1))) != '0;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // A new press restarts the timer and swallows any repeat expiring in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        rpt_fire = 1'b0;
        if (press_push) begin
            active_d = sel_code;
            cnt_d    = '0;
            state_d  = ST_DELAY;
        end else if (state_q != ST_IDLE) begin
            if (!keys_q[active_q]) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else if (state_q == ST_DELAY && cnt_q == DLY_LAST) begin
                cnt_d    = '0;
                rpt_fire = 1'b1;
                state_d  = ST_REPEAT;
            end else if (state_q == ST_REPEAT && cnt_q == PER_LAST) begin
                cnt_d    = '0;
                rpt_fire = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        fifo_push  = press_push || (rpt_fire && !fifo_full);
        overflow_d = rpt_fire && fifo_full;
        fifo_din   = press_push ? kbd_event_t'{rpt: 1'b0, code: sel_code}
                                : kbd_event_t'{rpt: 1'b1, code: active_q};
    end

    kbd_event_fifo #(
        .WIDTH ($bits(kbd_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (ev_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_code   = fifo_dout.code;
    assign ev_repeat = fifo_dout.rpt;
    assign overflow  = overflow_q;
    assign multi     = multi_q;
endmodule

// File: tb/tb_keyboard_event_decoder.sv
// Bench for keyboard_event_decoder: directed scenarios plus random key/ready traffic,
// checked by a scoreboard fed from a deadline-based reference model.
module tb_keyboard_event_decoder;
    localparam int RPT_DELAY  = 8;
    localparam int RPT_PERIOD = 4;
    localparam int DEPTH      = 4;

    logic        Clock;
    logic        Reset;
    logic [15:0] keys;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_repeat;
    logic        ev_ready;
    logic        overflow;
    logic        multi;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model state (owned by the monitor process)
    logic [15:0] m_keys_q;
    logic [15:0] m_pend;
    int          m_occ;
    bit          m_tmr_on;
    int          m_active;
    longint      m_due;
    longint      m_edge;
    bit          m_ovf;
    bit          m_multi;
    logic [4:0]  exp_q[$];

    keyboard_event_decoder #(
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD),
        .DEPTH      (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .keys      (keys),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_repeat (ev_repeat),
        .ev_ready  (ev_ready),
        .overflow  (overflow),
        .multi     (multi)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_keys_q = '0;
        m_pend   = '0;
        m_occ    = 0;
        m_tmr_on = 0;
        m_active = 0;
        m_due    = 0;
        m_edge   = 0;
        m_ovf    = 0;
        m_multi  = 0;
        exp_q.delete();
    endtask

    // Advance the model across one clock edge given the inputs the DUT sees at that edge.
    task automatic model_step(input logic [15:0] k, input logic rdy);
        longint      n         = m_edge + 1;
        bit          full      = (m_occ == DEPTH);
        bit          pop       = rdy && (m_occ > 0);
        int          pushes    = 0;
        int          code      = 0;
        logic [15:0] pend_next = m_pend;
        m_ovf = 0;
        if (m_pend != 0 && !full) begin
            while (!m_pend[code]) code++;
            exp_q.push_back({1'b0, 4'(code)});
            pushes          = 1;
            pend_next[code] = 1'b0;
            m_tmr_on        = 1;
            m_active        = code;
            m_due           = n + RPT_DELAY;
        end else if (m_tmr_on) begin
            if (!m_keys_q[m_active]) begin
                m_tmr_on = 0;
            end else if (n == m_due) begin
                m_due = n + RPT_PERIOD;
                if (full) m_ovf = 1;
                else begin
                    exp_q.push_back({1'b1, 4'(m_active)});
                    pushes = 1;
                end
            end
        end
        m_occ    = m_occ + pushes - (pop ? 1 : 0);
        m_pend   = (pend_next | (k & ~m_keys_q)) & k;
        m_keys_q = k;
        m_multi  = ($countones(k) > 1);
        m_edge   = n;
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    initial begin
        logic [4:0] e;
        model_reset();
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                check("reset ev_valid", 64'(ev_valid), 0);
                check("reset ev_code", 64'(ev_code), 0);
                check("reset ev_repeat", 64'(ev_repeat), 0);
                check("reset overflow", 64'(overflow), 0);
                check("reset multi", 64'(multi), 0);
                model_reset();
            end else begin
                check("ev_valid", 64'(ev_valid), 64'(m_occ > 0));
                check("overflow", 64'(overflow), 64'(m_ovf));
                check("multi", 64'(multi), 64'(m_multi));
                if (ev_valid && ev_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected event code", 64'({ev_repeat, ev_code}), 64'h1f_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_code", 64'(ev_code), 64'(e[3:0]));
                        check("ev_repeat", 64'(ev_repeat), 64'(e[4]));
                    end
                end
                model_step(keys, ev_ready);
            end
        end
    end

    task automatic cyc(input logic [15:0] k, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            keys     = k;
            ev_ready = r;
            @(posedge Clock);
            #2;
        end
    endtask

    initial begin
        logic [15:0] kr;
        int          prob;
        int          ovf_cnt;
        Reset    = 1'b1;
        keys     = '0;
        ev_ready = 1'b0;
        #1 Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #2 Reset = 1'b1;
        cyc(16'h0000, 1'b1, 3);

        // Single press: valid two edges after the change, no repeat for a short hold
        keys = 16'h0020; ev_ready = 1'b1;
        @(posedge Clock); #2;
        check("t1 valid after 1 edge", 64'(ev_valid), 0);
        @(posedge Clock); #2;
        check("t1 valid after 2 edges", 64'(ev_valid), 1);
        check("t1 code", 64'(ev_code), 5);
        check("t1 repeat", 64'(ev_repeat), 0);
        @(posedge Clock); #2;
        check("t1 popped", 64'(ev_valid), 0);
        cyc(16'h0000, 1'b1, 12);

        // Two keys in one cycle: queued lowest code first
        keys = 16'h0003; ev_ready = 1'b0;
        @(posedge Clock); #2;
        @(posedge Clock); #2;
        check("t2 multi", 64'(multi), 1);
        check("t2 first head", 64'(ev_code), 0);
        @(posedge Clock); #2;
        check("t2 head held", 64'(ev_code), 0);
        keys = 16'h0000; ev_ready = 1'b1;
        @(posedge Clock); #2;
        check("t2 second head", 64'(ev_code), 1);
        check("t2 second repeat", 64'(ev_repeat), 0);
        cyc(16'h0000, 1'b1, 12);

        // Held key: press, first repeat after delay, then periodic; release stops it
        cyc(16'h8000, 1'b1, 30);
        cyc(16'h0000, 1'b1, 15);

        // FIFO fills with press + 3 repeats; the next repeat is dropped with one pulse
        ovf_cnt = 0;
        keys = 16'h0001; ev_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(posedge Clock); #2;
            if (overflow) ovf_cnt++;
        end
        check("t4 overflow pulses", 64'(ovf_cnt), 1);
        check("t4 fifo full head", 64'(ev_code), 0);
        cyc(16'h0000, 1'b1, 12);

        // Second key during DELAY takes over the repeat timer
        cyc(16'h0004, 1'b1, 3);
        cyc(16'h0104, 1'b1, 20);
        cyc(16'h0000, 1'b1, 12);

        // Reset with queued events and timer in REPEAT
        cyc(16'h0000, 1'b1, 5);
        cyc(16'h0001, 1'b0, 14);
        check("t6 valid before reset", 64'(ev_valid), 1);
        Reset = 1'b0; keys = 16'h0000;
        #1;
        check("t6 valid in reset", 64'(ev_valid), 0);
        @(posedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b1;
        cyc(16'h0000, 1'b1, 10);
        cyc(16'h0002, 1'b1, 3);
        cyc(16'h0000, 1'b1, 10);

        // Random traffic
        kr   = '0;
        prob = 100;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: prob = 10;
                    1: prob = 50;
                    2: prob = 90;
                    default: prob = 100;
                endcase
            end
            r = $urandom_range(0, 23);
            if (r == 0) kr = '0;
            else if (r <= 2) begin
                int idx = $urandom_range(0, 15);
                kr[idx] = ~kr[idx];
            end
            cyc(kr, ($urandom_range(0, 99) < prob), 1);
        end

        cyc(16'h0000, 1'b1, 20);
        check("scoreboard drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
